// File: rtl/instr_pkg.sv
// Shared constants and encodings for the instruction fetch register slice.
package instr_pkg;

  localparam int DEF_IN_W      = 8;
  localparam int DEF_NUM_PARTS = 2;
  localparam int DEF_DEPTH     = 2;

  typedef enum logic {
    MODE_AUTO   = 1'b0,
    MODE_DIRECT = 1'b1
  } mode_e;

  // Slice selector width; a single-slice instruction still gets a 1-bit select.
  function automatic int sel_width(input int num_parts);
    return (num_parts > 1) ? $clog2(num_parts) : 1;
  endfunction

endpackage

// File: rtl/instr_queue.sv
// Shift-register FIFO: entry 0 is always the head, so the head data, valid
// flag and occupancy all come straight from flops.
module instr_queue
  import instr_pkg::*;
#(
  parameter int W     = DEF_IN_W * DEF_NUM_PARTS,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic                       valid,
  output logic [W-1:0]               data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  entries   [DEPTH];
  logic [W-1:0]  entries_n [DEPTH];
  logic [CW-1:0] count_n;
  logic [CW-1:0] wr_idx;
  logic          do_pop;
  logic          do_push;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count < CW'(DEPTH)) || do_pop);
  assign wr_idx  = count - CW'(do_pop);

  // Next-state: shift out the head on pop, then drop the new word into the first free slot.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    entries_n = entries;
    count_n   = count + CW'(do_push) - CW'(do_pop);
    if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) entries_n[i] = entries[i + 1];
    end
    if (do_push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_idx == CW'(i)) entries_n[i] = push_data;
      end
    end
    if (flush) begin
      count_n = '0;
      for (int i = 0; i < DEPTH; i++) entries_n[i] = '0;
    end
  end

  // Storage, occupancy and registered valid flag.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      // NOTE: storage is reset because entry 0 drives the visible head output, which must read zero in reset.
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      count <= '0;
      valid <= 1'b0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
      entries <= entries_n;
      count   <= count_n;
      valid   <= (count_n != '0);
    end
  end

  assign data = entries[0];

endmodule

// File: rtl/instruction_fetch_register.sv
// Assembles an instruction from IN_W-bit slices (sequentially or by address)
// and hands completed words to a small output queue.
module instruction_fetch_register
  import instr_pkg::*;
#(
  parameter int IN_W      = DEF_IN_W,
  parameter int NUM_PARTS = DEF_NUM_PARTS,
  parameter int DEPTH     = DEF_DEPTH
) (
  input  logic                              Clock,
  input  logic                              Reset,
  input  logic [IN_W-1:0]                   I,
  input  logic                              Write,
  input  logic                              Mode,
  input  logic [sel_width(NUM_PARTS)-1:0]   Sel,
  input  logic                              Commit,
  input  logic                              Flush,
  input  logic                              OutReady,
  output logic [IN_W*NUM_PARTS-1:0]         IROut,
  output logic                              WriteReady,
  output logic                              OutValid,
  output logic [IN_W*NUM_PARTS-1:0]         OutData,
  output logic [$clog2(DEPTH+1)-1:0]        Count
);

  localparam int W  = IN_W * NUM_PARTS;
  localparam int SW = sel_width(NUM_PARTS);
  localparam int CW = $clog2(DEPTH + 1);

  mode_e         mode;
  logic [SW-1:0] ptr;
  logic [SW-1:0] ptr_n;
  logic [SW-1:0] slot;
  logic [W-1:0]  ir_q;
  logic [W-1:0]  ir_n;
  logic          last;
  logic          space;
  logic          wr_en;
  logic          push;

  assign mode  = mode_e'(Mode);
  assign last  = (ptr == SW'(NUM_PARTS - 1));
  // Space counts a same-edge pop, so a full queue still takes a word while draining.
  assign space = (Count < CW'(DEPTH)) || (OutValid && OutReady);

  // Only the completing slice of an auto-mode instruction can be stalled.
  assign WriteReady = (mode == MODE_DIRECT) ? space : (!last || space);

  // Slice selection, pointer advance and push decision; the merged word is what gets pushed.
  always_comb begin
    slot  = ptr;
    wr_en = 1'b0;
    push  = 1'b0;
    ptr_n = ptr;
    if (mode == MODE_DIRECT) begin
      slot  = Sel;
      wr_en = Write;
      push  = Commit && space;
      ptr_n = '0;
    end else begin
      wr_en = Write && WriteReady;
      push  = wr_en && last;
      if (wr_en) ptr_n = last ? '0 : ptr + SW'(1);
    end

    // An out-of-range Sel matches no slice and therefore writes nothing.
    ir_n = ir_q;
    for (int p = 0; p < NUM_PARTS; p++) begin
      if (wr_en && (slot == SW'(p))) ir_n[p*IN_W +: IN_W] = I;
    end

    if (Flush) begin
      ptr_n = '0;
      ir_n  = '0;
      push  = 1'b0;
    end
  end

  // Assembly register and slice pointer.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ir_q <= '0;
      ptr  <= '0;
    end else begin
      ir_q <= ir_n;
      ptr  <= ptr_n;
    end
  end

  assign IROut = ir_q;

  instr_queue #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_queue (
    .Clock     (Clock),
    .Reset     (Reset),
    .push      (push),
    .push_data (ir_n),
    .pop       (OutValid && OutReady),
    .flush     (Flush),
    .valid     (OutValid),
    .data      (OutData),
    .count     (Count)
  );

endmodule

// File: tb/tb_instruction_fetch_register.sv
// Directed bench: stimulus pushes expected queue words into a scoreboard,
// a monitor pops and compares them whenever the DUT hands a word over.
module tb_instruction_fetch_register;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [7:0]  I;
  logic        Write;
  logic        Mode;
  logic [0:0]  Sel;
  logic        Commit;
  logic        Flush;
  logic        OutReady;
  logic [15:0] IROut;
  logic        WriteReady;
  logic        OutValid;
  logic [15:0] OutData;
  logic [1:0]  Count;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_q [$];

  instruction_fetch_register dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .I          (I),
    .Write      (Write),
    .Mode       (Mode),
    .Sel        (Sel),
    .Commit     (Commit),
    .Flush      (Flush),
    .OutReady   (OutReady),
    .IROut      (IROut),
    .WriteReady (WriteReady),
    .OutValid   (OutValid),
    .OutData    (OutData),
    .Count      (Count)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one edge and land 1ns after it, away from the sampling point.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    Write = 1'b0; Commit = 1'b0; Flush = 1'b0; OutReady = 1'b0;
  endtask

  task automatic auto_write(input logic [7:0] d);
    Mode = 1'b0; Write = 1'b1; I = d;
    step();
    Write = 1'b0;
  endtask

  // Monitor: a hand-over happens on the edge after a negedge that sees OutValid && OutReady.
  initial begin
    forever begin
      @(negedge Clock);
      if (!Reset && !Flush && OutValid && OutReady) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL pop_unexpected: got 0x%0h, expected no word", OutData);
        end else begin
          check("pop_data", {16'h0, OutData}, {16'h0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    Reset = 1'b1; I = '0; Sel = '0; Mode = 1'b0;
    idle();
    #2;
    // Reset values before any clock edge.
    check("rst_irout", {16'h0, IROut}, 32'h0);
    check("rst_count", {30'h0, Count}, 32'h0);
    check("rst_valid", {31'h0, OutValid}, 32'h0);
    check("rst_outdata", {16'h0, OutData}, 32'h0);
    check("rst_wready", {31'h0, WriteReady}, 32'h1);
    step();
    Reset = 1'b0;

    // Basic auto assembly: 0x34 then 0x12 -> 0x1234 pushed.
    auto_write(8'h34);
    check("auto_partial", {16'h0, IROut}, 32'h0034);
    exp_q.push_back(16'h1234);
    auto_write(8'h12);
    check("auto_irout", {16'h0, IROut}, 32'h1234);
    check("auto_count", {30'h0, Count}, 32'h1);
    check("auto_valid", {31'h0, OutValid}, 32'h1);
    check("auto_head", {16'h0, OutData}, 32'h1234);
    OutReady = 1'b1;
    step();
    OutReady = 1'b0;
    check("drain1_count", {30'h0, Count}, 32'h0);

    // Fill the queue with 0x1111 and 0x2222 while the consumer stalls.
    exp_q.push_back(16'h1111);
    auto_write(8'h11);
    auto_write(8'h11);
    exp_q.push_back(16'h2222);
    auto_write(8'h22);
    auto_write(8'h22);
    check("fill_count", {30'h0, Count}, 32'h2);
    // Clear the retained high slice directly (no commit) so the next word starts from 0x00xx.
    Mode = 1'b1; Sel = 1'b1; I = 8'h00; Write = 1'b1;
    #1;
    check("direct_full_wready", {31'h0, WriteReady}, 32'h0);
    step();
    Write = 1'b0;
    check("direct_nocommit_ir", {16'h0, IROut}, 32'h0022);
    check("direct_nocommit_cnt", {30'h0, Count}, 32'h2);
    auto_write(8'h33);
    check("full_first_slice", {16'h0, IROut}, 32'h0033);
    check("full_wready_low", {31'h0, WriteReady}, 32'h0);
    auto_write(8'h44);
    check("stalled_write_ir", {16'h0, IROut}, 32'h0033);
    check("stalled_write_cnt", {30'h0, Count}, 32'h2);

    // Same-edge pop of 0x1111 and push of 0x4433.
    exp_q.push_back(16'h4433);
    Mode = 1'b0; Write = 1'b1; I = 8'h44; OutReady = 1'b1;
    #1;
    check("pop_frees_wready", {31'h0, WriteReady}, 32'h1);
    step();
    idle();
    check("pushpop_count", {30'h0, Count}, 32'h2);
    check("pushpop_irout", {16'h0, IROut}, 32'h4433);
    OutReady = 1'b1;
    step();
    step();
    OutReady = 1'b0;
    check("drain2_count", {30'h0, Count}, 32'h0);
    check("drain2_valid", {31'h0, OutValid}, 32'h0);

    // Direct mode: Sel=1 0xAB, then Sel=0 0xCD with Commit -> 0xABCD.
    Mode = 1'b1; Sel = 1'b1; I = 8'hAB; Write = 1'b1;
    step();
    exp_q.push_back(16'hABCD);
    Sel = 1'b0; I = 8'hCD; Commit = 1'b1;
    step();
    idle();
    check("direct_irout", {16'h0, IROut}, 32'hABCD);
    check("direct_count", {30'h0, Count}, 32'h1);
    check("direct_head", {16'h0, OutData}, 32'hABCD);
    exp_q.push_back(16'hABCD);
    Commit = 1'b1;
    step();
    idle();
    check("direct_recommit_cnt", {30'h0, Count}, 32'h2);
    // Commit without space is dropped.
    Commit = 1'b1;
    step();
    idle();
    check("direct_nospace_cnt", {30'h0, Count}, 32'h2);

    // Flush beats Write and Pop: everything clears.
    Mode = 1'b0; Flush = 1'b1; Write = 1'b1; I = 8'h55; OutReady = 1'b1;
    exp_q.delete();
    step();
    idle();
    check("flush_count", {30'h0, Count}, 32'h0);
    check("flush_valid", {31'h0, OutValid}, 32'h0);
    check("flush_irout", {16'h0, IROut}, 32'h0);
    check("flush_wready", {31'h0, WriteReady}, 32'h1);
    auto_write(8'h66);
    check("flush_ptr0", {16'h0, IROut}, 32'h0066);

    // Mode toggle mid-assembly resets the pointer but keeps the partial word.
    Mode = 1'b1;
    step();
    check("mode_keeps_ir", {16'h0, IROut}, 32'h0066);
    auto_write(8'h77);
    check("mode_ptr0", {16'h0, IROut}, 32'h0077);

    // Asynchronous reset mid-assembly with a word queued.
    exp_q.push_back(16'h8877);
    auto_write(8'h88);
    auto_write(8'h99);
    check("pre_reset_count", {30'h0, Count}, 32'h1);
    check("pre_reset_irout", {16'h0, IROut}, 32'h8899);
    #1;
    Reset = 1'b1;
    exp_q.delete();
    #1;
    check("async_rst_irout", {16'h0, IROut}, 32'h0);
    check("async_rst_count", {30'h0, Count}, 32'h0);
    check("async_rst_valid", {31'h0, OutValid}, 32'h0);
    check("async_rst_data", {16'h0, OutData}, 32'h0);
    check("async_rst_wready", {31'h0, WriteReady}, 32'h1);
    step();
    #2;
    Reset = 1'b0;
    auto_write(8'h01);
    check("post_rst_slice0", {16'h0, IROut}, 32'h0001);
    check("post_rst_count", {30'h0, Count}, 32'h0);

    // Every queued expectation must have been handed over.
    check("scoreboard_empty", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_register.md
INSTRUCTION_FETCH_REGISTER -- requirements
Module: instruction_fetch_register

Interface
REQ-001 Parameter IN_W, default 8: width of one input slice.
REQ-002 Parameter NUM_PARTS, default 2: slices per instruction; W = IN_W*NUM_PARTS (16 at defaults).
REQ-003 Parameter DEPTH, default 2: output queue entries, >=1.
REQ-004 Clock  input  1  single clock; all state on rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 I  input  IN_W  slice data.
REQ-007 Write  input  1  slice write strobe.
REQ-008 Mode  input  1  0 = auto-sequential, 1 = direct-addressed.
REQ-009 Sel  input  max(1,clog2(NUM_PARTS))  target slice in direct mode; 0 = least significant.
REQ-010 Commit  input  1  direct mode: push assembled word to queue.
REQ-011 Flush  input  1  synchronous clear of assembly and queue.
REQ-012 OutReady  input  1  consumer accepts queue head.
REQ-013 IROut  output  W  assembly register, partial contents visible.
REQ-014 WriteReady  output  1  Write/Commit will be accepted this cycle.
REQ-015 OutValid  output  1  queue non-empty.
REQ-016 OutData  output  W  queue head; valid only when OutValid=1.
REQ-017 Count  output  clog2(DEPTH+1)  queue occupancy.

Function
REQ-018 Pop occurs when OutValid && OutReady; Push occurs per REQ-020/REQ-022; space exists when Count<DEPTH or Pop this cycle.
REQ-019 Auto mode: accepted Write loads I into slice Ptr of IROut, other slices held; Ptr increments 0..NUM_PARTS-1, wraps to 0.
REQ-020 Auto mode: Write with Ptr=NUM_PARTS-1 pushes the merged word (including this I) in the same edge; Push with Pop same edge leaves Count unchanged.
REQ-021 Auto mode: WriteReady=0 only when Ptr=NUM_PARTS-1 and no space; Write while WriteReady=0 is ignored (IROut, Ptr unchanged).
REQ-022 Direct mode: Write loads I into slice Sel; Sel>=NUM_PARTS ignored; Commit pushes IROut merged with any same-cycle Write; Ptr held at 0.
REQ-023 Direct mode: WriteReady = space; Commit without space is ignored, Write still applies.
REQ-024 IROut is not cleared on push; next instruction overwrites slices.
REQ-025 Queue is FIFO order; OutData/OutValid/Count registered, Pop latency zero (head updates edge after Pop).
REQ-026 Push into empty queue: OutValid=1 and OutData valid the following cycle.
REQ-027 Flush has priority over Write, Commit, Pop: IROut=0, Ptr=0, Count=0 next edge.
REQ-028 Mode change mid-assembly: Ptr forced to 0 whenever Mode=1; partial IROut retained.

Reset
REQ-029 Reset asserted: IROut=0, Ptr=0, Count=0, OutValid=0, OutData=0, WriteReady=1, immediately, no clock needed.
REQ-030 Reset mid-assembly or with queue full discards all contents; first cycle after release behaves as empty, Ptr=0.

Structure
REQ-031 Shared package instr_pkg holds default IN_W/NUM_PARTS/DEPTH constants and MODE_AUTO=0/MODE_DIRECT=1 encodings.
REQ-032 Queue is a sub-module instr_queue (parameters W, DEPTH; push, pop, flush, data, count), also usable standalone.
REQ-033 Ptr and slice write logic stay in the top module; no combinational path from OutReady to WriteReady except via space.

Verification
REQ-034 Reset, auto: Write 0x34 then 0x12 -> IROut=0x1234, OutValid=1, OutData=0x1234, Count=1.
REQ-035 Auto fill: push 0x1111, 0x2222 with OutReady=0 -> Count=2, then Write 0x33 accepted, Write 0x44 ignored (WriteReady=0), IROut=0x0033.
REQ-036 Full queue, OutReady=1 during last-slice Write 0x44 -> Pop 0x1111, Push 0x4433 same edge, Count stays 2.
REQ-037 Direct: Sel=1 I=0xAB, then Sel=0 I=0xCD with Commit same cycle -> pushed 0xABCD.
REQ-038 Flush and Write same cycle with Count=2 -> Count=0, OutValid=0, IROut=0, Ptr=0.
REQ-039 Reset asserted between edges mid-assembly -> all outputs zero asynchronously; post-release Write 0x01 lands in slice 0.
